// File: rtl/byte_mem_ctrl.sv
// Byte-serial memory controller: word-level IF/MEM requests serialized onto an 8-bit RAM/IO bus.
// Optional macro BYTE_MEM_CTRL_IO_WAIT_EN stalls I/O-region stores while the UART tx buffer is full.
module byte_mem_ctrl #(
  parameter int          ADDR_W = 32,
  parameter logic [1:0]  IO_HI  = 2'b11
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_done_o,
  output logic [31:0]       if_rdata_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_size_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              mem_done_o,
  output logic [31:0]       mem_rdata_o,
  input  logic              io_full_i,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t            state;
  logic              is_if;
  logic [1:0]        last;
  logic [2:0]        cnt;
  logic [ADDR_W-1:0] base;
  logic [31:0]       wdata_q;
  logic [31:0]       rbuf;
  logic [31:0]       merged;
  logic              wr_q;
  logic [1:0]        mem_last;
  logic              io_block;

`ifdef BYTE_MEM_CTRL_IO_WAIT_EN
  assign io_block = mem_req_i && mem_we_i && (mem_addr_i[17:16] == IO_HI) && io_full_i;
`else
  // io_full_i is intentionally ignored in this build
  assign io_block = 1'b0 & io_full_i & (mem_addr_i[17:16] == IO_HI);
`endif

  assign mem_last = (mem_size_i == 2'd2) ? 2'd3 : mem_size_i;

  // A frozen cycle must never repeat a write strobe, so the strobe is gated by rdy_in
  assign mem_wr = wr_q & rdy_in;

  // Byte k returns two edges after its address was issued, i.e. while cnt == k + 2
  always_comb begin
    merged = rbuf;
    for (int unsigned i = 0; i < 4; i++) begin
      if (cnt == 3'(i + 2)) merged[8*i +: 8] = mem_din;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= IDLE;
      is_if       <= 1'b0;
      last        <= '0;
      cnt         <= '0;
      base        <= '0;
      wdata_q     <= '0;
      rbuf        <= '0;
      wr_q        <= 1'b0;
      mem_a       <= '0;
      mem_dout    <= '0;
      if_done_o   <= 1'b0;
      mem_done_o  <= 1'b0;
      if_rdata_o  <= '0;
      mem_rdata_o <= '0;
    end else if (rdy_in) begin
      if_done_o  <= 1'b0;
      mem_done_o <= 1'b0;
      case (state)
        IDLE: begin
          wr_q <= 1'b0;
          if (!if_done_o && !mem_done_o && !io_block) begin
            if (mem_req_i) begin
              is_if   <= 1'b0;
              base    <= mem_addr_i;
              last    <= mem_last;
              wdata_q <= mem_wdata_i;
              rbuf    <= '0;
              cnt     <= 3'd1;
              mem_a   <= mem_addr_i;
              if (mem_we_i) begin
                state      <= WRITE;
                wr_q       <= 1'b1;
                mem_dout   <= mem_wdata_i[7:0];
                mem_done_o <= (mem_last == 2'd0);
              end else begin
                state <= READ;
              end
            end else if (if_req_i && !if_flush_i) begin
              is_if <= 1'b1;
              base  <= if_addr_i;
              last  <= 2'd3;
              rbuf  <= '0;
              cnt   <= 3'd1;
              mem_a <= if_addr_i;
              state <= READ;
            end
          end
        end
        READ: begin
          if (is_if && if_flush_i) begin
            state <= IDLE;
          end else begin
            if (cnt <= {1'b0, last}) mem_a <= base + ADDR_W'(cnt);
            if (cnt >= 3'd2) rbuf <= merged;
            if (cnt == {1'b0, last} + 3'd2) begin
              state <= IDLE;
              if (is_if) begin
                if_done_o  <= 1'b1;
                if_rdata_o <= merged;
              end else begin
                mem_done_o  <= 1'b1;
                mem_rdata_o <= merged;
              end
            end
            cnt <= cnt + 3'd1;
          end
        end
        WRITE: begin
          if (cnt <= {1'b0, last}) begin
            mem_a      <= base + ADDR_W'(cnt);
            mem_dout   <= wdata_q[{cnt[1:0], 3'b000} +: 8];
            mem_done_o <= (cnt[1:0] == last);
            cnt        <= cnt + 3'd1;
          end else begin
            wr_q  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_mem_ctrl.sv
// Self-checking bench for byte_mem_ctrl: synchronous RAM model, write log and expected-result queues.
module tb_byte_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        mem_req, mem_we, mem_done, io_full;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t0 = 0;
  int if_done_seen = 0;

  logic [7:0]  ram [logic [31:0]];
  logic [39:0] wr_log[$];
  logic [39:0] exp_wr_q[$];
  logic [31:0] exp_if_q[$];
  logic [31:0] exp_mem_q[$];

  byte_mem_ctrl #(.ADDR_W(32), .IO_HI(2'b11)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .if_done_o(if_done), .if_rdata_o(if_rdata),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_size_i(mem_size),
    .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .mem_done_o(mem_done), .mem_rdata_o(mem_rdata),
    .io_full_i(io_full), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
    if (mem_wr) begin
      ram[mem_a] = mem_dout;
      wr_log.push_back({mem_a, mem_dout});
    end
  end

  always @(negedge clk) if (if_done) if_done_seen <= if_done_seen + 1;

  task automatic wait_done(input bit for_if, output int lat, output bit ok);
    ok = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (for_if ? if_done : mem_done) begin
        ok = 1'b1;
        lat = cyc - t0;
        return;
      end
    end
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; if_req = 0; if_flush = 0; if_addr = '0;
    mem_req = 0; mem_we = 0; mem_size = 0; mem_addr = '0; mem_wdata = '0; io_full = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if ({mem_a, mem_dout, mem_wr} !== 41'h0) begin miscompares++; $display("FAIL reset_bus: got %h want 0", {mem_a, mem_dout, mem_wr}); end
    vectors++; if ({if_done, mem_done} !== 2'b00) begin miscompares++; $display("FAIL reset_done: got %b want 00", {if_done, mem_done}); end
    vectors++; if ({if_rdata, mem_rdata} !== 64'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", {if_rdata, mem_rdata}); end
    @(posedge clk); #1 rst = 1'b0;
    settle();
  endtask

  task automatic test_if_read();
    int lat; bit ok; logic [31:0] exp;
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h10; ram[32'h103] = 8'h00;
    if_req = 1'b1; if_addr = 32'h100; exp_if_q.push_back(32'h00100513);
    @(posedge clk); #1 t0 = cyc;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++; if (mem_a !== 32'h100 + k || mem_wr !== 1'b0) begin miscompares++; $display("FAIL if_addr_step%0d: got a=%h wr=%b want a=%h wr=0", k, mem_a, mem_wr, 32'h100 + k); end
    end
    wait_done(1'b1, lat, ok);
    if_req = 1'b0;
    exp = exp_if_q.pop_front();
    vectors++; if (!ok) begin miscompares++; $display("FAIL if_done_timeout: got none want pulse"); end
    vectors++; if (lat !== 5) begin miscompares++; $display("FAIL if_latency: got %0d want 5", lat); end
    vectors++; if (if_rdata !== exp) begin miscompares++; $display("FAIL if_rdata: got %h want %h", if_rdata, exp); end
    @(negedge clk);
    vectors++; if (if_done !== 1'b0) begin miscompares++; $display("FAIL if_done_width: got %b want 0", if_done); end
    settle();
  endtask

  task automatic test_simultaneous();
    int lat; bit ok; logic [31:0] exp;
    ram[32'h2000] = 8'hFF;
    if_req = 1'b1; if_addr = 32'h100; exp_if_q.push_back(32'h00100513);
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'h2000; exp_mem_q.push_back(32'h000000FF);
    @(posedge clk); #1 t0 = cyc;
    @(negedge clk);
    vectors++; if (mem_a !== 32'h2000) begin miscompares++; $display("FAIL prio_first_addr: got %h want 00002000", mem_a); end
    wait_done(1'b0, lat, ok);
    mem_req = 1'b0;
    exp = exp_mem_q.pop_front();
    vectors++; if (!ok || lat !== 2) begin miscompares++; $display("FAIL byte_read_latency: got ok=%b lat=%0d want ok=1 lat=2", ok, lat); end
    vectors++; if (mem_rdata !== exp) begin miscompares++; $display("FAIL byte_read_rdata: got %h want %h", mem_rdata, exp); end
    @(negedge clk);
    vectors++; if (mem_a !== 32'h2000) begin miscompares++; $display("FAIL turnaround_hold: got %h want 00002000", mem_a); end
    @(negedge clk);
    vectors++; if (mem_a !== 32'h100) begin miscompares++; $display("FAIL if_after_mem: got %h want 00000100", mem_a); end
    wait_done(1'b1, lat, ok);
    if_req = 1'b0;
    exp = exp_if_q.pop_front();
    vectors++; if (!ok || if_rdata !== exp) begin miscompares++; $display("FAIL if_after_mem_rdata: got ok=%b %h want %h", ok, if_rdata, exp); end
    settle();
  endtask

  task automatic test_half_store();
    logic [39:0] e;
    ram[32'h30] = 8'h00; ram[32'h31] = 8'h00; ram[32'h32] = 8'h55;
    wr_log.delete();
    exp_wr_q.push_back({32'h30, 8'hEF}); exp_wr_q.push_back({32'h31, 8'hBE});
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd1; mem_addr = 32'h30; mem_wdata = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    vectors++; if ({mem_wr, mem_a, mem_dout, mem_done} !== {1'b1, 32'h30, 8'hEF, 1'b0}) begin miscompares++; $display("FAIL half_store_b0: got wr=%b a=%h d=%h done=%b want 1 30 ef 0", mem_wr, mem_a, mem_dout, mem_done); end
    @(negedge clk);
    vectors++; if ({mem_wr, mem_a, mem_dout, mem_done} !== {1'b1, 32'h31, 8'hBE, 1'b1}) begin miscompares++; $display("FAIL half_store_b1: got wr=%b a=%h d=%h done=%b want 1 31 be 1", mem_wr, mem_a, mem_dout, mem_done); end
    mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    vectors++; if (mem_wr !== 1'b0) begin miscompares++; $display("FAIL half_store_end: got wr=%b want 0", mem_wr); end
    vectors++; if (wr_log.size() !== 2) begin miscompares++; $display("FAIL half_store_count: got %0d want 2", wr_log.size()); end
    while (exp_wr_q.size() > 0 && wr_log.size() > 0) begin
      e = exp_wr_q.pop_front();
      vectors++; if (wr_log[0] !== e) begin miscompares++; $display("FAIL half_store_log: got %h want %h", wr_log[0], e); end
      void'(wr_log.pop_front());
    end
    exp_wr_q.delete();
    vectors++; if (ram[32'h32] !== 8'h55) begin miscompares++; $display("FAIL half_store_neighbor: got %h want 55", ram[32'h32]); end
    settle();
  endtask

  task automatic test_flush();
    int lat; bit ok; int seen0; logic [31:0] exp;
    ram[32'h200] = 8'h78; ram[32'h201] = 8'h56; ram[32'h202] = 8'h34; ram[32'h203] = 8'h12;
    seen0 = if_done_seen;
    if_req = 1'b1; if_addr = 32'h100;
    @(posedge clk);
    @(posedge clk); #1 if_flush = 1'b1;
    @(posedge clk); #1 if_flush = 1'b0; if_req = 1'b0;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd3; mem_addr = 32'h200; exp_mem_q.push_back(32'h12345678);
    @(posedge clk); #1 t0 = cyc;
    @(negedge clk);
    vectors++; if (mem_a !== 32'h200) begin miscompares++; $display("FAIL flush_then_mem: got %h want 00000200", mem_a); end
    wait_done(1'b0, lat, ok);
    mem_req = 1'b0;
    exp = exp_mem_q.pop_front();
    vectors++; if (!ok || lat !== 5) begin miscompares++; $display("FAIL word_load_latency: got ok=%b lat=%0d want ok=1 lat=5", ok, lat); end
    vectors++; if (mem_rdata !== exp) begin miscompares++; $display("FAIL word_load_rdata: got %h want %h", mem_rdata, exp); end
    vectors++; if (if_done_seen !== seen0) begin miscompares++; $display("FAIL flush_no_done: got %0d pulses want 0", if_done_seen - seen0); end
    vectors++; if (if_rdata !== 32'h00100513) begin miscompares++; $display("FAIL flush_rdata_hold: got %h want 00100513", if_rdata); end
    settle();
  endtask

  task automatic test_rdy_pause();
    int lat; bit ok; int n; logic [39:0] e;
    wr_log.delete();
    for (int k = 0; k < 4; k++) begin
      ram[32'h400 + k] = 8'h00;
    end
    exp_wr_q.push_back({32'h400, 8'h44}); exp_wr_q.push_back({32'h401, 8'h33});
    exp_wr_q.push_back({32'h402, 8'h22}); exp_wr_q.push_back({32'h403, 8'h11});
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd3; mem_addr = 32'h400; mem_wdata = 32'h11223344;
    @(posedge clk);
    @(posedge clk); #1 rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if (mem_wr !== 1'b0 || mem_a !== 32'h401) begin miscompares++; $display("FAIL pause_cycle%0d: got wr=%b a=%h want wr=0 a=401", i, mem_wr, mem_a); end
      @(posedge clk);
    end
    #1 rdy = 1'b1;
    wait_done(1'b0, lat, ok);
    mem_req = 1'b0; mem_we = 1'b0;
    vectors++; if (!ok) begin miscompares++; $display("FAIL pause_done_timeout: got none want pulse"); end
    repeat (2) @(negedge clk);
    n = wr_log.size();
    vectors++; if (n !== 4) begin miscompares++; $display("FAIL pause_write_count: got %0d want 4", n); end
    while (exp_wr_q.size() > 0 && wr_log.size() > 0) begin
      e = exp_wr_q.pop_front();
      vectors++; if (wr_log[0] !== e) begin miscompares++; $display("FAIL pause_log: got %h want %h", wr_log[0], e); end
      vectors++; if (ram[e[39:8]] !== e[7:0]) begin miscompares++; $display("FAIL pause_image: got %h want %h", ram[e[39:8]], e[7:0]); end
      void'(wr_log.pop_front());
    end
    exp_wr_q.delete();
    settle();
  endtask

  task automatic test_reset_mid();
    int seen0;
    seen0 = if_done_seen;
    if_req = 1'b1; if_addr = 32'h100;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; if_req = 1'b0;
    @(negedge clk);
    vectors++; if ({mem_a, if_rdata, mem_rdata} !== 96'h0) begin miscompares++; $display("FAIL reset_mid_vals: got %h want 0", {mem_a, if_rdata, mem_rdata}); end
    repeat (8) @(negedge clk);
    vectors++; if (if_done_seen !== seen0) begin miscompares++; $display("FAIL reset_mid_done: got %0d pulses want 0", if_done_seen - seen0); end
    settle();
  endtask

  task automatic test_io_write();
    int lat; bit ok; logic [39:0] e;
    ram[32'h30000] = 8'h00;
    wr_log.delete();
    exp_wr_q.push_back({32'h30000, 8'h41});
    io_full = 1'b1;
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd0; mem_addr = 32'h30000; mem_wdata = 32'h41;
`ifdef BYTE_MEM_CTRL_IO_WAIT_EN
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++; if (mem_wr !== 1'b0) begin miscompares++; $display("FAIL io_wait_cycle%0d: got wr=%b want 0", i, mem_wr); end
    end
    io_full = 1'b0;
`endif
    wait_done(1'b0, lat, ok);
    mem_req = 1'b0; mem_we = 1'b0; io_full = 1'b0;
    vectors++; if (!ok) begin miscompares++; $display("FAIL io_done_timeout: got none want pulse"); end
    repeat (4) @(negedge clk);
    vectors++; if (wr_log.size() !== 1) begin miscompares++; $display("FAIL io_write_count: got %0d want 1", wr_log.size()); end
    if (wr_log.size() > 0) begin
      e = exp_wr_q.pop_front();
      vectors++; if (wr_log[0] !== e) begin miscompares++; $display("FAIL io_write_log: got %h want %h", wr_log[0], e); end
    end
    exp_wr_q.delete();
    settle();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_if_read();
    test_simultaneous();
    test_half_store();
    test_flush();
    test_rdy_pause();
    test_reset_mid();
    test_io_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
